// File: rtl/instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// instr_prefetch_queue
//
// Purpose:
//   Sequential instruction prefetcher sitting in front of the IF stage. It
//   fetches consecutive words from a variable-latency instruction memory over a
//   req/ack handshake and buffers up to DEPTH {pc, instr} pairs. IF consumes
//   the head entry with a valid/ready handshake. A redirect (taken branch or
//   jump) flushes the queue and restarts fetching at redirect_pc.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset        synchronous active-high reset
//   redirect     flush the queue and restart fetch at redirect_pc
//   redirect_pc  new fetch address, sampled while redirect=1
//   mem_req      instruction memory request
//   mem_addr     word address of the request, held stable while mem_req=1
//   mem_ack      memory completion, ignored while mem_req=0
//   mem_rdata    instruction word, valid when mem_req && mem_ack
//   ins_valid    head entry valid
//   ins_data     head instruction
//   ins_pc       address of the head instruction
//   ins_ready    IF accepts the head (pop on ins_valid && ins_ready)
//   count        number of valid entries
// -----------------------------------------------------------------------------
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       mem_req,
  output logic [31:0]                mem_addr,
  input  logic                       mem_ack,
  input  logic [31:0]                mem_rdata,
  output logic                       ins_valid,
  output logic [31:0]                ins_data,
  output logic [31:0]                ins_pc,
  input  logic                       ins_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // IDLE: no request. REQ: fetching at fetch_pc. DISCARD: the outstanding
  // request belongs to a flushed stream; its data is thrown away on ack.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  // Address of the request still in flight while in DISCARD; fetch_pc
  // already holds the redirect target at that point.
  logic [31:0]   disc_addr_q, disc_addr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];

  logic xfer;
  logic push;
  logic pop;

  assign xfer = mem_req && mem_ack;
  // Redirect overrides both queue operations on the same edge.
  assign push = xfer && (state_q == REQ) && !redirect;
  assign pop  = ins_valid && ins_ready && !redirect;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    disc_addr_d = disc_addr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    if (redirect) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = redirect_pc;
      if (state_q == REQ && !xfer) begin
        // The old request cannot be withdrawn; remember its address so
        // mem_addr stays stable until the memory completes it.
        state_d     = DISCARD;
        disc_addr_d = fetch_pc_q;
      end else if (state_q == DISCARD && !xfer) begin
        state_d = DISCARD;
      end else begin
        state_d = REQ;
      end
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);

      // A request is only issued when a slot is free after this edge, so
      // its eventual ack always has room.
      unique case (state_q)
        IDLE:    if (count_d < FULL) state_d = REQ;
        REQ:     if (xfer && count_d >= FULL) state_d = IDLE;
        DISCARD: if (xfer) state_d = REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      disc_addr_q <= RESET_PC;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      disc_addr_q <= disc_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Payload storage carries no reset; ins_valid gates its use.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
      data_mem_q[wr_ptr_q] <= mem_rdata;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_addr  = (state_q == DISCARD) ? disc_addr_q : fetch_pc_q;
  assign ins_valid = (count_q != '0);
  assign ins_pc    = pc_mem_q[rd_ptr_q];
  assign ins_data  = data_mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_prefetch_queue
//
// Bench for instr_prefetch_queue. A behavioural memory answers requests after
// a programmable number of wait cycles with data derived from the address.
// Each scenario task pushes the pc stream it expects into exp_q; a monitor
// logs every accepted head entry into obs_q, and the task compares the two
// in order, together with inline checks of the control outputs.
// -----------------------------------------------------------------------------
module tb_instr_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        ins_valid;
  logic [31:0] ins_data;
  logic [31:0] ins_pc;
  logic        ins_ready = 1'b0;
  logic [2:0]  count;

  int   ack_lat = 0;
  int   wait_cnt = 0;
  logic late_ack = 1'b0;
  int   xfers = 0;

  int   tests_run = 0;
  int   tests_failed = 0;

  logic [63:0] obs_q[$];
  int          obs_rd = 0;
  logic [31:0] exp_q[$];

  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ins_valid(ins_valid), .ins_data(ins_data), .ins_pc(ins_pc), .ins_ready(ins_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_func(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  // Memory model: ack after ack_lat wait cycles (0 = same cycle as req).
  assign mem_rdata = mem_func(mem_addr);
  assign mem_ack   = (mem_req && (wait_cnt >= ack_lat)) || late_ack;

  always @(posedge clk) begin
    if (reset || !mem_req || mem_ack) wait_cnt <= 0;
    else                              wait_cnt <= wait_cnt + 1;
    if (mem_req && mem_ack) xfers <= xfers + 1;
  end

  // Inputs change only 1 time unit after a rising edge, so what is seen here
  // is what the next rising edge acts on.
  always @(negedge clk) begin
    if (!reset && !redirect && ins_valid && ins_ready)
      obs_q.push_back({ins_pc, ins_data});
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input int lat, input logic rdy);
    ack_lat   = lat;
    ins_ready = rdy;
    redirect  = 1'b0;
    late_ack  = 1'b0;
    reset     = 1'b1;
    step(2);
    reset     = 1'b0;
    obs_rd    = obs_q.size();
    exp_q.delete();
  endtask

  task automatic push_exp(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(i * 4));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
    tests_run++; if (mem_addr !== RESET_PC) begin tests_failed++; $display("FAIL rst_mem_addr got=%h exp=%h", mem_addr, RESET_PC); end
    tests_run++; if (ins_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_ins_valid got=%b exp=0", ins_valid); end
    tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL rst_count got=%0d exp=0", count); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_zero_wait();
    int n;
    logic [31:0] e;
    start(0, 1'b1);
    step(1);
    tests_run++; if (ins_valid !== 1'b0) begin tests_failed++; $display("FAIL zw_valid_c1 got=%b exp=0", ins_valid); end
    tests_run++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin tests_failed++; $display("FAIL zw_req_c1 got=%b/%h exp=1/00000000", mem_req, mem_addr); end
    step(1);
    tests_run++; if (ins_valid !== 1'b1 || ins_pc !== 32'h0) begin tests_failed++; $display("FAIL zw_first got=%b/%h exp=1/00000000", ins_valid, ins_pc); end
    step(10);
    ins_ready = 1'b0;
    tests_run++; if (count !== 3'd1) begin tests_failed++; $display("FAIL zw_count got=%0d exp=1", count); end
    push_exp(32'h0, 10);
    n = obs_q.size() - obs_rd;
    tests_run++; if (n !== exp_q.size()) begin tests_failed++; $display("FAIL zw_npops got=%0d exp=%0d", n, exp_q.size()); end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      tests_run++; if (obs_q[obs_rd] !== {e, mem_func(e)}) begin tests_failed++; $display("FAIL zw_pop got=%h exp=%h", obs_q[obs_rd], {e, mem_func(e)}); end
      obs_rd++;
    end
    $display("[TB] test_zero_wait done");
  endtask

  task automatic test_fill();
    int n;
    int x0;
    logic [31:0] e;
    start(0, 1'b0);
    x0 = xfers;
    step(8);
    tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL fill_req got=%b exp=0", mem_req); end
    tests_run++; if (count !== 3'd4) begin tests_failed++; $display("FAIL fill_count got=%0d exp=4", count); end
    tests_run++; if (xfers - x0 !== 4) begin tests_failed++; $display("FAIL fill_xfers got=%0d exp=4", xfers - x0); end
    tests_run++; if (ins_pc !== 32'h0) begin tests_failed++; $display("FAIL fill_head got=%h exp=00000000", ins_pc); end
    ins_ready = 1'b1;
    step(1);
    tests_run++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin tests_failed++; $display("FAIL fill_rereq got=%b/%h exp=1/00000010", mem_req, mem_addr); end
    tests_run++; if (count !== 3'd3) begin tests_failed++; $display("FAIL fill_count_pop got=%0d exp=3", count); end
    step(3);
    ins_ready = 1'b0;
    push_exp(32'h0, 4);
    n = obs_q.size() - obs_rd;
    tests_run++; if (n !== exp_q.size()) begin tests_failed++; $display("FAIL fill_npops got=%0d exp=%0d", n, exp_q.size()); end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      tests_run++; if (obs_q[obs_rd] !== {e, mem_func(e)}) begin tests_failed++; $display("FAIL fill_pop got=%h exp=%h", obs_q[obs_rd], {e, mem_func(e)}); end
      obs_rd++;
    end
    $display("[TB] test_fill done");
  endtask

  task automatic test_redirect_wait();
    int n;
    logic [31:0] e;
    start(3, 1'b1);
    step(1);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step(1);
    redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests_run++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin tests_failed++; $display("FAIL rw_hold%0d got=%b/%h exp=1/00000000", k, mem_req, mem_addr); end
      step(1);
    end
    tests_run++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin tests_failed++; $display("FAIL rw_new_addr got=%b/%h exp=1/00000100", mem_req, mem_addr); end
    tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL rw_dropped got=%0d exp=0", count); end
    step(20);
    push_exp(32'h100, 4);
    n = obs_q.size() - obs_rd;
    tests_run++; if (n !== exp_q.size()) begin tests_failed++; $display("FAIL rw_npops got=%0d exp=%0d", n, exp_q.size()); end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      tests_run++; if (obs_q[obs_rd] !== {e, mem_func(e)}) begin tests_failed++; $display("FAIL rw_pop got=%h exp=%h", obs_q[obs_rd], {e, mem_func(e)}); end
      obs_rd++;
    end
    $display("[TB] test_redirect_wait done");
  endtask

  // Redirect on the same edge as a transfer; base selects the target so the
  // same scenario also covers fetch_pc wrap-around.
  task automatic test_redirect_ack(input logic [31:0] base);
    int n;
    logic [31:0] e;
    start(0, 1'b0);
    step(1);
    redirect = 1'b1;
    redirect_pc = base;
    step(1);
    redirect = 1'b0;
    ins_ready = 1'b1;
    tests_run++; if (count !== 3'd0 || ins_valid !== 1'b0) begin tests_failed++; $display("FAIL ra_flush got=%0d/%b exp=0/0", count, ins_valid); end
    tests_run++; if (mem_req !== 1'b1 || mem_addr !== base) begin tests_failed++; $display("FAIL ra_new_addr got=%b/%h exp=1/%h", mem_req, mem_addr, base); end
    step(5);
    ins_ready = 1'b0;
    push_exp(base, 4);
    n = obs_q.size() - obs_rd;
    tests_run++; if (n !== exp_q.size()) begin tests_failed++; $display("FAIL ra_npops got=%0d exp=%0d", n, exp_q.size()); end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      tests_run++; if (obs_q[obs_rd] !== {e, mem_func(e)}) begin tests_failed++; $display("FAIL ra_pop got=%h exp=%h", obs_q[obs_rd], {e, mem_func(e)}); end
      obs_rd++;
    end
    $display("[TB] test_redirect_ack base=%h done", base);
  endtask

  task automatic test_redirect_pop();
    int n;
    logic [31:0] e;
    start(0, 1'b0);
    step(4);
    tests_run++; if (count !== 3'd3 || ins_valid !== 1'b1) begin tests_failed++; $display("FAIL rp_pre got=%0d/%b exp=3/1", count, ins_valid); end
    ins_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h300;
    step(1);
    redirect = 1'b0;
    tests_run++; if (count !== 3'd0 || ins_valid !== 1'b0) begin tests_failed++; $display("FAIL rp_flush got=%0d/%b exp=0/0", count, ins_valid); end
    tests_run++; if (mem_addr !== 32'h300) begin tests_failed++; $display("FAIL rp_addr got=%h exp=00000300", mem_addr); end
    step(1);
    tests_run++; if (ins_valid !== 1'b1 || ins_pc !== 32'h300) begin tests_failed++; $display("FAIL rp_first got=%b/%h exp=1/00000300", ins_valid, ins_pc); end
    step(2);
    ins_ready = 1'b0;
    push_exp(32'h300, 2);
    n = obs_q.size() - obs_rd;
    tests_run++; if (n !== exp_q.size()) begin tests_failed++; $display("FAIL rp_npops got=%0d exp=%0d", n, exp_q.size()); end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      tests_run++; if (obs_q[obs_rd] !== {e, mem_func(e)}) begin tests_failed++; $display("FAIL rp_pop got=%h exp=%h", obs_q[obs_rd], {e, mem_func(e)}); end
      obs_rd++;
    end
    $display("[TB] test_redirect_pop done");
  endtask

  task automatic test_reset_mid();
    start(3, 1'b0);
    step(2);
    tests_run++; if (mem_req !== 1'b1 || mem_ack !== 1'b0) begin tests_failed++; $display("FAIL rm_pending got=%b/%b exp=1/0", mem_req, mem_ack); end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    late_ack = 1'b1;
    tests_run++; if (mem_req !== 1'b0 || count !== 3'd0) begin tests_failed++; $display("FAIL rm_state got=%b/%0d exp=0/0", mem_req, count); end
    tests_run++; if (mem_addr !== RESET_PC) begin tests_failed++; $display("FAIL rm_addr got=%h exp=%h", mem_addr, RESET_PC); end
    step(1);
    late_ack = 1'b0;
    tests_run++; if (count !== 3'd0 || ins_valid !== 1'b0) begin tests_failed++; $display("FAIL rm_late_ack got=%0d/%b exp=0/0", count, ins_valid); end
    tests_run++; if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin tests_failed++; $display("FAIL rm_restart got=%b/%h exp=1/%h", mem_req, mem_addr, RESET_PC); end
    step(4);
    tests_run++; if (count !== 3'd1 || ins_pc !== RESET_PC) begin tests_failed++; $display("FAIL rm_first got=%0d/%h exp=1/%h", count, ins_pc, RESET_PC); end
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_fill();
    test_redirect_wait();
    test_redirect_ack(32'h0000_0200);
    test_redirect_pop();
    test_reset_mid();
    test_redirect_ack(32'hFFFF_FFF8);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
